uart_tx_frame: RTL and testbench

- UART transmitter: accepts a parallel byte plus frame configuration and serialises it onto TX_OUT as start bit, LSB-first data, optional parity bit, then stop bit.
- Transmit-side counterpart of the UART RX path; uses the same PAR_EN/PAR_TYP conventions and frame format.
- Runs on the bit clock: one TX_OUT bit per clk cycle.
- Bit-rate division is done upstream by the clock divider.

---
 rtl/uart_tx_frame.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises one byte per frame as start, LSB-first data, optional parity, stop.
// Optional one-entry holding buffer for back-to-back frames: define UART_TX_HOLD_BUF_EN.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  tx_active
);

  localparam int unsigned CntW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    active_q, active_d;

  logic                    accept;
  logic                    load;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    load_pen;
  logic                    load_ptyp;

  assign accept = Data_Valid & ~busy_q;

`ifdef UART_TX_HOLD_BUF_EN
  logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
  logic                    hold_pen_q, hold_pen_d;
  logic                    hold_ptyp_q, hold_ptyp_d;
  logic                    hold_full_q, hold_full_d;
  logic                    direct;
  logic                    drain;

  // A request goes straight to the shifter only when the line and buffer are both empty.
  assign direct = accept & (state_q == StIdle) & ~hold_full_q;
  assign drain  = hold_full_q & ((state_q == StStop) | (state_q == StIdle));
  assign load   = direct | drain;

  always_comb begin
    load_data = P_DATA;
    load_pen  = PAR_EN;
    load_ptyp = PAR_TYP;
    if (drain) begin
      load_data = hold_data_q;
      load_pen  = hold_pen_q;
      load_ptyp = hold_ptyp_q;
    end
  end

  always_comb begin
    hold_data_d = hold_data_q;
    hold_pen_d  = hold_pen_q;
    hold_ptyp_d = hold_ptyp_q;
    // A refill on the drain edge keeps the buffer full.
    hold_full_d = (hold_full_q & ~drain) | (accept & ~direct);
    if (accept && !direct) begin
      hold_data_d = P_DATA;
      hold_pen_d  = PAR_EN;
      hold_ptyp_d = PAR_TYP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data_q <= '0;
      hold_pen_q  <= 1'b0;
      hold_ptyp_q <= 1'b0;
      hold_full_q <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_pen_q  <= hold_pen_d;
      hold_ptyp_q <= hold_ptyp_d;
      hold_full_q <= hold_full_d;
    end
  end
`else
  assign load      = accept & (state_q == StIdle);
  assign load_data = P_DATA;
  assign load_pen  = PAR_EN;
  assign load_ptyp = PAR_TYP;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      active_q  <= active_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;

    case (state_q)
      StIdle: begin
        if (load) state_d = StStart;
      end
      StStart: begin
        state_d = StData;
        cnt_d   = '0;
      end
      StData: begin
        shift_d = shift_q >> 1;
        if (cnt_q == LastCnt) begin
          state_d = par_en_q ? StParity : StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: begin
        state_d = StStop;
      end
      StStop: begin
        state_d = load ? StStart : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (load) begin
      shift_d   = load_data;
      par_en_d  = load_pen;
      par_bit_d = (^load_data) ^ load_ptyp;
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_bit_d;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    active_d = (state_d != StIdle);
`ifdef UART_TX_HOLD_BUF_EN
    busy_d = hold_full_d;
`else
    busy_d = active_d;
`endif
  end

  assign TX_OUT    = tx_q;
  assign busy      = busy_q;
  assign tx_active = active_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: expected line bits come from a frame-level model.
// Holding-buffer scenarios run when UART_TX_HOLD_BUF_EN is defined.
module tb_uart_tx_frame;

`ifdef UART_TX_HOLD_BUF_EN
  localparam bit HoldBuf = 1'b1;
`else
  localparam bit HoldBuf = 1'b0;
`endif
  // With the buffer, busy only reflects a full buffer, so a lone frame leaves it low.
  localparam logic BusyInFrame = HoldBuf ? 1'b0 : 1'b1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       tx_out;
  logic       busy;
  logic       tx_active;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .P_DATA    (p_data),
    .Data_Valid(data_valid),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .TX_OUT    (tx_out),
    .busy      (busy),
    .tx_active (tx_active)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame model: start 0, data LSB first, parity from ones count, stop 1.
  task automatic model_frame(input logic [7:0] d, input bit pen, input bit ptyp);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) exp_q.push_back(ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1));
    exp_q.push_back(1'b1);
  endtask

  task automatic start_request(input logic [7:0] d, input bit pen, input bit ptyp);
    p_data     = d;
    par_en     = pen;
    par_typ    = ptyp;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #23;
    rst = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0 || tx_active !== 1'b0) begin
        $display("FAIL reset_idle cyc=%0d got tx=%b busy=%b act=%b want tx=1 busy=0 act=0",
                 i, tx_out, busy, tx_active);
        n_fail++;
      end
      tick();
    end
    exp_q.delete();
    start_request(8'hA5, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (tx_out !== 1'b1) begin
      $display("FAIL reset_mid_tx got %b want 1", tx_out); n_fail++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_mid_busy got %b want 0", busy); n_fail++;
    end
    n_checks++;
    if (tx_active !== 1'b0) begin
      $display("FAIL reset_mid_active got %b want 0", tx_active); n_fail++;
    end
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (tx_out !== 1'b1 || tx_active !== 1'b0) begin
      $display("FAIL reset_after got tx=%b act=%b want tx=1 act=0", tx_out, tx_active);
      n_fail++;
    end
  endtask

  task automatic test_basic_frame();
    int len;
    exp_q.delete();
    model_frame(8'hA5, 1'b0, 1'b0);
    len = exp_q.size();
    start_request(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      n_checks++;
      if (tx_out !== exp_q[i] || busy !== BusyInFrame || tx_active !== 1'b1) begin
        $display("FAIL basic_bit%0d got tx=%b busy=%b act=%b want tx=%b busy=%b act=1",
                 i, tx_out, busy, tx_active, exp_q[i], BusyInFrame);
        n_fail++;
      end
      tick();
    end
    n_checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || tx_active !== 1'b0) begin
      $display("FAIL basic_end got tx=%b busy=%b act=%b want 1/0/0", tx_out, busy, tx_active);
      n_fail++;
    end
  endtask

  task automatic test_parity();
    for (int t = 0; t < 2; t++) begin
      exp_q.delete();
      model_frame(8'hA5, 1'b1, t[0]);
      start_request(8'hA5, 1'b1, t[0]);
      for (int i = 0; i < 11; i++) begin
        n_checks++;
        if (tx_out !== exp_q[i] || tx_active !== 1'b1) begin
          $display("FAIL parity_typ%0d_bit%0d got tx=%b act=%b want tx=%b act=1",
                   t, i, tx_out, tx_active, exp_q[i]);
          n_fail++;
        end
        tick();
      end
      n_checks++;
      if (tx_active !== 1'b0 || tx_out !== 1'b1) begin
        $display("FAIL parity_len%0d got act=%b tx=%b want act=0 tx=1", t, tx_active, tx_out);
        n_fail++;
      end
    end
  endtask

  task automatic test_config_latched();
    exp_q.delete();
    model_frame(8'h07, 1'b1, 1'b0);
    start_request(8'h07, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (tx_out !== exp_q[i]) begin
        $display("FAIL latched_bit%0d got %b want %b", i, tx_out, exp_q[i]);
        n_fail++;
      end
      p_data  = 8'($urandom);
      par_typ = ~par_typ;
      par_en  = 1'($urandom);
      tick();
    end
    n_checks++;
    if (tx_active !== 1'b0) begin
      $display("FAIL latched_end got act=%b want 0", tx_active); n_fail++;
    end
  endtask

`ifndef UART_TX_HOLD_BUF_EN
  task automatic test_ignore_busy();
    exp_q.delete();
    model_frame(8'hA5, 1'b0, 1'b0);
    start_request(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (tx_out !== exp_q[i]) begin
        $display("FAIL ignore_bit%0d got %b want %b", i, tx_out, exp_q[i]);
        n_fail++;
      end
      if (i == 3) begin
        p_data     = 8'h3C;
        data_valid = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0 || tx_active !== 1'b0) begin
        $display("FAIL ignore_idle%0d got tx=%b busy=%b act=%b want 1/0/0",
                 i, tx_out, busy, tx_active);
        n_fail++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bit exp_busy;
    exp_q.delete();
    model_frame(8'h55, 1'b0, 1'b0);
    exp_q.push_back(1'b1);
    model_frame(8'h55, 1'b0, 1'b0);
    p_data     = 8'h55;
    par_en     = 1'b0;
    data_valid = 1'b1;
    tick();
    for (int i = 0; i < 21; i++) begin
      exp_busy = (i != 10);
      n_checks++;
      if (tx_out !== exp_q[i] || busy !== exp_busy) begin
        $display("FAIL held_bit%0d got tx=%b busy=%b want tx=%b busy=%b",
                 i, tx_out, busy, exp_q[i], exp_busy);
        n_fail++;
      end
      if (i == 20) data_valid = 1'b0;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_out !== 1'b1 || tx_active !== 1'b0) begin
        $display("FAIL held_tail%0d got tx=%b act=%b want 1/0", i, tx_out, tx_active);
        n_fail++;
      end
      tick();
    end
  endtask
`else
  task automatic test_hold_buffer();
    bit exp_busy;
    exp_q.delete();
    model_frame(8'h11, 1'b0, 1'b0);
    model_frame(8'h22, 1'b0, 1'b0);
    start_request(8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      exp_busy = (i >= 2 && i <= 9);
      n_checks++;
      if (tx_out !== exp_q[i] || busy !== exp_busy || tx_active !== 1'b1) begin
        $display("FAIL hold_bit%0d got tx=%b busy=%b act=%b want tx=%b busy=%b act=1",
                 i, tx_out, busy, tx_active, exp_q[i], exp_busy);
        n_fail++;
      end
      if (i == 1) begin
        p_data     = 8'h22;
        data_valid = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      tick();
    end
    n_checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || tx_active !== 1'b0) begin
      $display("FAIL hold_end got tx=%b busy=%b act=%b want 1/0/0", tx_out, busy, tx_active);
      n_fail++;
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] d;
    bit         pen;
    bit         ptyp;
    int         len;
    for (int f = 0; f < 8; f++) begin
      d    = 8'($urandom);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      exp_q.delete();
      model_frame(d, pen, ptyp);
      len = exp_q.size();
      start_request(d, pen, ptyp);
      for (int i = 0; i < len; i++) begin
        n_checks++;
        if (tx_out !== exp_q[i] || tx_active !== 1'b1) begin
          $display("FAIL rand_f%0d_d%02h_bit%0d got tx=%b act=%b want tx=%b act=1",
                   f, d, i, tx_out, tx_active, exp_q[i]);
          n_fail++;
        end
        tick();
      end
      n_checks++;
      if (tx_out !== 1'b1 || tx_active !== 1'b0) begin
        $display("FAIL rand_f%0d_end got tx=%b act=%b want 1/0", f, tx_out, tx_active);
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_config_latched();
`ifndef UART_TX_HOLD_BUF_EN
    test_ignore_busy();
    test_back_to_back();
`else
    test_hold_buffer();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
